// File: rtl/encoder_arbiter_pkg.sv
// Shared definitions for the encoder-family blocks: FSM state encodings
// and a helper that extracts one channel from a packed value bus.
package enc_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // Widest channel and widest packed bus the slice helper supports.
    localparam int unsigned MAX_W   = 32;
    localparam int unsigned MAX_BUS = 16 * MAX_W;

    // Returns channel idx of a bus packed as width-bit slices, zero-extended.
    function automatic logic [MAX_W-1:0] chan_slice(
        input logic [MAX_BUS-1:0] bus,
        input int unsigned        idx,
        input int unsigned        width
    );
        logic [MAX_BUS-1:0] sh;
        logic [MAX_W-1:0]   mask;
        sh   = bus >> (idx * width);
        mask = ~({MAX_W{1'b1}} << width);
        return sh[MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/encoder_arbiter_if.sv
// Shared-output bus between the encoder counters and the single consumer.
interface encoder_arbiter_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
);
    logic [NUM_CH*WIDTH-1:0] values;
    logic                    active;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_value;
    logic                    grant;

    // Encoder/consumer side: supplies channel values, observes ownership.
    modport master (
        output values,
        input  active, sel, out_value, grant
    );

    // Arbiter side.
    modport slave (
        input  values,
        output active, sel, out_value, grant
    );
endinterface

// File: rtl/encoder_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr+1.
module rr_pick #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    // Scan NUM_CH positions starting one past the pointer, keep the first hit.
    always_comb begin
        int unsigned        c;
        logic [NUM_CH-1:0]  req_sh;
        idx    = '0;
        any    = 1'b0;
        c      = 0;
        req_sh = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            c      = (32'(ptr) + k) % NUM_CH;
            req_sh = req >> c;
            if (!any && req_sh[0]) begin
                any = 1'b1;
                idx = SEL_W'(c);
            end
        end
    end

endmodule

// File: rtl/encoder_arbiter.sv
// Grants the shared output to whichever encoder channel last changed,
// holding ownership through HOLD_CYCLES of inactivity.
module encoder_arbiter
    import enc_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned MAXVAL      = 255,
    parameter int unsigned WIDTH       = $clog2(MAXVAL),
    parameter int unsigned HOLD_CYCLES = 1000,
    parameter int unsigned SEL_W       = $clog2(NUM_CH),
    parameter int unsigned CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    encoder_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [NUM_CH*WIDTH-1:0] prev_q;
    logic                    primed_q;
    logic [SEL_W-1:0]        rr_q, rr_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    active_q, active_d;
    logic                    grant_q, grant_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]        out_q, out_d;

    logic [NUM_CH-1:0]       chg;
    logic [NUM_CH-1:0]       chg_sh;
    logic                    own_chg;
    logic [SEL_W-1:0]        pick;
    logic                    pick_any;

    // Per-channel change flags; suppressed until one clock has loaded prev.
    always_comb begin
        chg = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            chg[i] = primed_q &&
                     (bus.values[i*WIDTH +: WIDTH] != prev_q[i*WIDTH +: WIDTH]);
        end
    end

    assign chg_sh  = chg >> sel_q;
    assign own_chg = chg_sh[0];

    rr_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_pick (
        .req (chg),
        .ptr (rr_q),
        .idx (pick),
        .any (pick_any)
    );

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            prev_q   <= '0;
            primed_q <= 1'b0;
            rr_q     <= '0;
            sel_q    <= '0;
            active_q <= 1'b0;
            grant_q  <= 1'b0;
            cnt_q    <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= bus.values;
            primed_q <= 1'b1;
            rr_q     <= rr_d;
            sel_q    <= sel_d;
            active_q <= active_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

    // Next-state: leave OWN only when the hold expires with nothing to re-grant.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (pick_any) state_d = ST_OWN;
            ST_OWN:  if (!own_chg && cnt_q == '0 && !pick_any) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Ownership, hold counter and grant pulse for each transition.
    always_comb begin
        sel_d    = sel_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        grant_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                active_d = 1'b0;
                if (pick_any) begin
                    sel_d    = pick;
                    rr_d     = pick;
                    cnt_d    = RELOAD;
                    active_d = 1'b1;
                    grant_d  = 1'b1;
                end
            end
            ST_OWN: begin
                if (own_chg) begin
                    cnt_d = RELOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (pick_any) begin
                    sel_d   = pick;
                    rr_d    = pick;
                    cnt_d   = RELOAD;
                    grant_d = 1'b1;
                end else begin
                    active_d = 1'b0;
                end
            end
            default: begin
                active_d = 1'b0;
            end
        endcase
        out_d = WIDTH'(chan_slice(MAX_BUS'(bus.values), 32'(sel_d), WIDTH));
    end

    assign bus.active    = active_q;
    assign bus.sel       = sel_q;
    assign bus.out_value = out_q;
    assign bus.grant     = grant_q;

endmodule

// File: tb/tb_encoder_arbiter.sv
module tb_encoder_arbiter;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned HOLD   = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [NUM_CH*WIDTH-1:0] vals;

    int errors = 0;
    int checks = 0;

    encoder_arbiter_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();
    assign bus.values = vals;

    encoder_arbiter #(
        .NUM_CH      (NUM_CH),
        .MAXVAL      (255),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int unsigned ch, input logic [7:0] v);
        vals[ch*WIDTH +: WIDTH] = v;
    endtask

    function automatic logic [7:0] get_ch(input int unsigned ch);
        return vals[ch*WIDTH +: WIDTH];
    endfunction

    initial begin
        bit seen;
        int unsigned exp_sel [4];
        exp_sel = '{1, 2, 3, 0};

        // Reset with static values 10,20,30,40
        vals = {8'd40, 8'd30, 8'd20, 8'd10};
        #1 reset = 1'b1;
        #3;
        check("rst_active", 32'(bus.active), 0);
        check("rst_sel", 32'(bus.sel), 0);
        check("rst_out", 32'(bus.out_value), 0);
        check("rst_grant", 32'(bus.grant), 0);
        #10 reset = 1'b0;

        // Static values for 20 cycles: no grant ever
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (bus.grant !== 1'b0 || bus.active !== 1'b0) seen = 1'b1;
        end
        check("static_no_grant", 32'(seen), 0);

        // ch2 30->31
        set_ch(2, 8'd31);
        tick();
        check("ch2_grant", 32'(bus.grant), 1);
        check("ch2_sel", 32'(bus.sel), 2);
        check("ch2_active", 32'(bus.active), 1);
        check("ch2_out", 32'(bus.out_value), 31);
        tick();
        check("ch2_grant_pulse", 32'(bus.grant), 0);
        repeat (6) tick();
        check("ch2_hold_last", 32'(bus.active), 1);
        tick();
        check("ch2_release", 32'(bus.active), 0);
        check("ch2_sel_kept", 32'(bus.sel), 2);

        // ch1 takes ownership; ch3 changes every cycle but cannot preempt
        set_ch(1, 8'd21);
        tick();
        check("ch1_grant", 32'(bus.grant), 1);
        check("ch1_sel", 32'(bus.sel), 1);
        seen = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            set_ch(3, get_ch(3) + 8'd1);
            tick();
            if (bus.sel !== 2'd1 || bus.grant !== 1'b0 || bus.active !== 1'b1) seen = 1'b1;
        end
        check("ch1_no_preempt", 32'(seen), 0);
        set_ch(3, get_ch(3) + 8'd1);
        tick();
        check("ch3_regrant", 32'(bus.grant), 1);
        check("ch3_sel", 32'(bus.sel), 3);
        check("ch3_active", 32'(bus.active), 1);
        check("ch3_out", 32'(bus.out_value), 48);
        repeat (8) tick();
        check("ch3_release", 32'(bus.active), 0);

        // Reset rr, then all-channel bursts rotate 1,2,3,0
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        tick();
        check("prime_no_grant", 32'(bus.grant), 0);
        for (int b = 0; b < 4; b++) begin
            for (int unsigned c = 0; c < NUM_CH; c++) set_ch(c, get_ch(c) + 8'd1);
            tick();
            check("burst_grant", 32'(bus.grant), 1);
            check("burst_sel", 32'(bus.sel), 32'(exp_sel[b]));
            check("burst_out", 32'(bus.out_value), 32'(get_ch(exp_sel[b])));
            repeat (8) tick();
            check("burst_release", 32'(bus.active), 0);
        end

        // ch0 to 255, release, then wrap 255->0
        set_ch(0, 8'd255);
        tick();
        check("ch0_to_max_sel", 32'(bus.sel), 0);
        repeat (8) tick();
        check("ch0_max_release", 32'(bus.active), 0);
        set_ch(0, 8'd0);
        tick();
        check("wrap_grant", 32'(bus.grant), 1);
        check("wrap_sel", 32'(bus.sel), 0);
        check("wrap_out", 32'(bus.out_value), 0);
        seen = 1'b0;
        for (int t = 0; t < 4; t++) begin
            repeat (4) begin
                tick();
                if (bus.grant !== 1'b0 || bus.active !== 1'b1) seen = 1'b1;
            end
            set_ch(0, ~get_ch(0));
            tick();
            if (bus.grant !== 1'b0 || bus.active !== 1'b1) seen = 1'b1;
        end
        check("toggle_hold", 32'(seen), 0);
        repeat (9) tick();
        check("toggle_release", 32'(bus.active), 0);

        // Fresh grant, then asynchronous reset between edges
        set_ch(2, get_ch(2) + 8'd1);
        tick();
        check("pre_rst_grant", 32'(bus.grant), 1);
        check("pre_rst_sel", 32'(bus.sel), 2);
        #2 reset = 1'b1;
        #1;
        check("async_active", 32'(bus.active), 0);
        check("async_grant", 32'(bus.grant), 0);
        check("async_sel", 32'(bus.sel), 0);
        #10 reset = 1'b0;
        tick();
        check("post_rst_grant", 32'(bus.grant), 0);
        check("post_rst_active", 32'(bus.active), 0);
        tick();
        check("post_rst_grant2", 32'(bus.grant), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
